// File: rtl/clk_enable_gen_if.sv
// clk_enable_gen_if: configuration write channel of the clock-enable generator
interface clk_enable_gen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 32
);
    localparam int CH_W = $clog2(NUM_CH) + 1;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_clr;
    logic             cfg_err;
    modport master (output cfg_valid, cfg_ch, cfg_inc, cfg_clr, input cfg_ready, cfg_err);
    modport slave (input cfg_valid, cfg_ch, cfg_inc, cfg_clr, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel fractional clock-enable generator with programmable increments and lock status
module clk_enable_gen #(
    parameter int                       NUM_CH      = 2,
    parameter int                       ACC_W       = 32,
    parameter int                       LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0]  INC_INIT    = {NUM_CH{32'h4000_0000}}
) (
    input  logic              clk_100m,
    input  logic              reset,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] en_o,
    output logic [NUM_CH-1:0] locked,
    clk_enable_gen_if.slave   cfg
);
    localparam int CH_W = $clog2(NUM_CH) + 1;
    localparam int LC_W = $clog2(LOCK_CYCLES + 1);
    logic wr, wr_ok, err_d, ready_q, err_q;
    assign wr        = cfg.cfg_valid & cfg.cfg_ready;
    assign wr_ok     = wr & (cfg.cfg_ch < CH_W'(NUM_CH));
    assign err_d     = wr & ~wr_ok;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;
    always_ff @(posedge clk_100m) begin
        ready_q <= ~reset;
        err_q   <= ~reset & err_d;
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ACC_W-1:0] acc_q, acc_d, inc_q, inc_d;
        logic [LC_W-1:0]  cnt_q, cnt_d;
        logic             en_q, en_d, locked_q, locked_d, sel, clr;
        logic [ACC_W:0]   sum;
        assign sel = wr_ok & (cfg.cfg_ch == CH_W'(c));
        assign clr = sync_i | (sel & cfg.cfg_clr);
        // the add always uses the old increment, so a write without clear keeps phase
        assign sum = {1'b0, acc_q} + {1'b0, inc_q};
        always_comb begin
            acc_d    = clr ? '0 : sum[ACC_W-1:0];
            en_d     = ~clr & sum[ACC_W];
            inc_d    = sel ? cfg.cfg_inc : inc_q;
            cnt_d    = sel ? '0 : (cnt_q < LC_W'(LOCK_CYCLES)) ? cnt_q + 1'b1 : cnt_q;
            locked_d = ~sel & ((cnt_q == LC_W'(LOCK_CYCLES - 1)) | locked_q);
        end
        always_ff @(posedge clk_100m) begin
            if (reset) begin
                acc_q    <= '0;
                inc_q    <= INC_INIT[c*ACC_W +: ACC_W];
                cnt_q    <= '0;
                en_q     <= 1'b0;
                locked_q <= 1'b0;
            end else begin
                acc_q    <= acc_d;
                inc_q    <= inc_d;
                cnt_q    <= cnt_d;
                en_q     <= en_d;
                locked_q <= locked_d;
            end
        end
        assign en_o[c]   = en_q;
        assign locked[c] = locked_q;
    end
endmodule
